// File: rtl/ser2par_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// ser2par_deserializer_pkg : shared state encoding and parameter legality checks
// Revision: 1.0
// ============================================================================
package ser2par_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int c_min_width = 2;
    localparam int c_max_width = 64;

    function automatic bit width_is_legal(input int width);
        return (width >= c_min_width) && (width <= c_max_width);
    endfunction

    function automatic bit msb_first_is_legal(input int msb_first);
        return (msb_first == 0) || (msb_first == 1);
    endfunction

    function automatic int bit_count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ser2par_bit_counter.sv
`default_nettype none
// ============================================================================
// ser2par_bit_counter : modulo-WIDTH bit counter with restart and terminal count
// Revision: 1.0
// ============================================================================
module ser2par_bit_counter
    import ser2par_deserializer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tc
);

    localparam int c_cnt_w = bit_count_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [c_cnt_w-1:0] r_count;

    // A restart consumes the accepted bit as bit 0, so the count lands on 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (en) begin
            if (restart) begin
                r_count <= c_cnt_w'(1);
            end else if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end
    end

    assign tc = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/ser2par_deserializer.sv
`default_nettype none
// ============================================================================
// ser2par_deserializer : framed serial stream to WIDTH-bit valid/ready words
// Revision: 1.0
// ============================================================================
module ser2par_deserializer
    import ser2par_deserializer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_bit,
    input  logic             ser_valid,
    output logic             ser_ready,
    input  logic             sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_cnt
);

    generate
        if (!width_is_legal(WIDTH) || !msb_first_is_legal(MSB_FIRST) || (CNT_W < 1)) begin : g_bad_params
            $error("ser2par_deserializer: illegal WIDTH, MSB_FIRST or CNT_W");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_load_data;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_handshake;
    logic             w_tc;
    logic             w_complete;
    logic             w_load;

    assign ser_ready   = (r_state != FULL);
    assign w_accept    = ser_valid && ser_ready;
    assign w_slot_free = !out_valid || out_ready;
    assign w_handshake = out_valid && out_ready;

    // sof outranks completion: a sof on what would be the last bit restarts the word.
    assign w_complete  = w_accept && !sof && (r_state == SHIFT) && w_tc;
    assign w_load      = (w_complete || (r_state == FULL)) && w_slot_free;
    assign w_load_data = (r_state == FULL) ? r_shift : w_shift_next;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], ser_bit};
            assign w_first      = {{(WIDTH-1){1'b0}}, ser_bit};
        end else begin : g_lsb_first
            assign w_shift_next = {ser_bit, r_shift[WIDTH-1:1]};
            assign w_first      = {ser_bit, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    ser2par_bit_counter #(
        .WIDTH   (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .en      (w_accept),
        .restart (sof),
        .tc      (w_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            word_cnt  <= '0;
        end else begin
            frame_err <= w_accept && sof && (r_state == SHIFT);

            if (w_handshake) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end

            // Starting fresh flushes leftovers of the previous or discarded word.
            if (w_accept) begin
                r_shift <= (sof || (r_state == IDLE)) ? w_first : w_shift_next;
            end

            if (w_load) begin
                out_data  <= w_load_data;
                out_valid <= 1'b1;
            end else if (w_handshake) begin
                out_valid <= 1'b0;
            end

            case (r_state)
                IDLE:    if (w_accept)    r_state <= SHIFT;
                SHIFT:   if (w_complete)  r_state <= w_slot_free ? IDLE : FULL;
                FULL:    if (w_slot_free) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
